// File: rtl/core_if.sv
// Instruction-fetch stage: owns the fetch PC, one outstanding imem request, delivers {inst,pc,pc4} to ID.
// Latency: IF_regs loads on the edge that sees rvalid (or on stall release from the hold buffer).
// Backpressure: stall holds IF_regs; a response arriving under stall parks in a one-entry hold buffer.
package core_if_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] pc4;
    } IF_regs_t;
endpackage

module core_if
    import core_if_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output IF_regs_t    IF_regs,
    output logic [63:0] next_pc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] w_pc_nxt;
    logic [63:0] r_inflight_pc;
    logic [63:0] w_inflight_nxt;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_hold_inst;
    logic [63:0] r_hold_pc;
    logic        w_hold_load;
    IF_regs_t    r_if_regs;
    logic        w_deliver;
    IF_regs_t    w_deliver_dat;
    logic        w_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_drop        <= 1'b0;
            r_hold_inst   <= 32'h0;
            r_hold_pc     <= 64'h0;
            r_if_regs     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_inflight_pc <= w_inflight_nxt;
            r_drop        <= w_drop_nxt;
            if (w_hold_load) begin
                r_hold_inst <= imem_rdata;
                r_hold_pc   <= r_inflight_pc;
            end
            if (flush) begin
                r_if_regs <= '0;
            end else if (w_deliver) begin
                r_if_regs <= w_deliver_dat;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inflight_nxt = r_inflight_pc;
        w_drop_nxt     = r_drop;
        w_hold_load    = 1'b0;
        w_deliver      = 1'b0;
        w_deliver_dat  = '0;
        w_req          = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = !redirect_valid;
                if (w_req && imem_ready) begin
                    w_inflight_nxt = r_pc;
                    w_pc_nxt       = r_pc + 64'd4;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (redirect_valid) begin
                        w_state_nxt = S_REQ;
                    end else if (stall) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        // Deliver and issue the next fetch in the same cycle.
                        w_deliver     = 1'b1;
                        w_deliver_dat = '{inst: imem_rdata, pc: r_inflight_pc,
                                          pc4: r_inflight_pc + 64'd4};
                        w_req         = 1'b1;
                        if (imem_ready) begin
                            w_inflight_nxt = r_pc;
                            w_pc_nxt       = r_pc + 64'd4;
                        end else begin
                            w_state_nxt = S_REQ;
                        end
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_deliver     = 1'b1;
                    w_deliver_dat = '{inst: r_hold_inst, pc: r_hold_pc,
                                      pc4: r_hold_pc + 64'd4};
                    w_state_nxt   = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
        if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
        end
    end

    always_comb begin
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (r_state == S_HOLD) begin
            next_pc = r_hold_pc;
        end else if (r_state == S_WAIT && !r_drop) begin
            next_pc = r_inflight_pc;
        end else begin
            next_pc = r_pc;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign IF_regs   = r_if_regs;

endmodule

// File: tb/tb_core_if.sv
// Randomized bench for core_if: memory model, program-order scoreboard, and directed corner phases.
`timescale 1ns/1ps
module tb_core_if;
    import core_if_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [63:0] next_pc;
    IF_regs_t    IF_regs;

    core_if #(.RESET_PC(64'h0)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_regs(IF_regs), .next_pc(next_pc)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Program-order scoreboard: the stream of PCs ID should see, restarted on every redirect.
    logic [63:0] exp_q[$];
    logic [63:0] stream_pc;

    function automatic void sb_refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(stream_pc);
            stream_pc = stream_pc + 64'd4;
        end
    endfunction

    function automatic void sb_restart(input logic [63:0] pc);
        exp_q.delete();
        stream_pc = pc;
        sb_refill();
    endfunction

    int          cur_edge = 0;
    int          n_deliv = 0;
    int          deliv_edge_q[$];
    logic [63:0] deliv_pc_q[$];
    int          acc_edge_q[$];
    logic [63:0] acc_addr_q[$];

    function automatic void clear_logs();
        deliv_edge_q.delete();
        deliv_pc_q.delete();
        acc_edge_q.delete();
        acc_addr_q.delete();
    endfunction

    IF_regs_t    mon_prev;
    logic [63:0] mon_e;
    initial begin
        mon_prev = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                mon_prev = '0;
            end else begin
                if (flush) begin
                    check("flush_inst", {32'h0, IF_regs.inst}, 64'h0);
                    check("flush_pc", IF_regs.pc, 64'h0);
                end else if (IF_regs != mon_prev) begin
                    if (stall) begin
                        check("stall_hold_pc", IF_regs.pc, mon_prev.pc);
                    end else if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_underflow: got pc %h expected no delivery", IF_regs.pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_pc", IF_regs.pc, mon_e);
                        check("sb_inst", {32'h0, IF_regs.inst}, {32'h0, mem_word(mon_e)});
                        check("sb_pc4", IF_regs.pc4, mon_e + 64'd4);
                        deliv_pc_q.push_back(IF_regs.pc);
                        deliv_edge_q.push_back(cur_edge);
                        n_deliv++;
                    end
                end
                mon_prev = IF_regs;
            end
        end
    end

    int          lat_min = 1, lat_max = 1, ready_pct = 100, stall_pct = 0, redir_pct = 0;
    bit          pend = 0;
    logic [63:0] pend_addr = 64'h0;
    int          pend_due = 0;
    bit          exp_acc_vld = 0;
    logic [63:0] exp_acc_addr = 64'h0;
    bit          stall_hook_en = 0;
    logic [63:0] stall_hook_addr = 64'h0;
    int          stall_left = 0;
    int          stall_hook_edge = -1;
    int          redir_hook_mode = 0;
    logic [63:0] redir_hook_addr = 64'h0;
    logic [63:0] redir_hook_tgt = 64'h0;
    int          redir_hook_edge = -1;

    function automatic logic [63:0] random_target();
        logic [63:0] v;
        if ($urandom_range(7) == 0) begin
            v = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3) * 4);
        end else begin
            v = {32'h0, $urandom} & 64'h0000_0000_000F_FFFC;
        end
        return v;
    endfunction

    // One cycle: memory model response/acceptance plus stall/redirect stimulus for the next edge.
    task automatic step();
        bit          responding;
        logic [63:0] resp_addr;
        bit          do_redir;
        logic [63:0] tgt;
        @(negedge clock);
        cur_edge++;
        responding = pend && (pend_due == cur_edge);
        resp_addr  = pend_addr;
        if (responding) pend = 0;
        imem_rvalid = responding;
        imem_rdata  = responding ? mem_word(resp_addr) : $urandom;
        imem_ready  = ($urandom_range(99) < ready_pct);
        if (stall_hook_en && responding && resp_addr == stall_hook_addr) begin
            stall_hook_en   = 0;
            stall_left      = 3;
            stall_hook_edge = cur_edge;
        end
        if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end else begin
            stall = ($urandom_range(99) < stall_pct);
        end
        do_redir = ($urandom_range(99) < redir_pct);
        tgt      = random_target();
        if ((redir_hook_mode == 1 && pend && pend_addr == redir_hook_addr) ||
            (redir_hook_mode == 2 && responding && resp_addr == redir_hook_addr) ||
            (redir_hook_mode == 3)) begin
            do_redir        = 1;
            tgt             = redir_hook_tgt;
            redir_hook_mode = 0;
            redir_hook_edge = cur_edge;
        end
        redirect_valid = do_redir;
        flush          = do_redir;
        redirect_pc    = tgt;
        if (do_redir) begin
            sb_restart(tgt);
            exp_acc_vld  = 1;
            exp_acc_addr = tgt;
        end
        sb_refill();
        #1;
        if (do_redir) begin
            check("redir_next_pc", next_pc, tgt);
            check("redir_no_req", 64'(imem_req), 64'h0);
        end
        if (pend) check("one_outstanding", 64'(imem_req), 64'h0);
        if (imem_req && imem_ready) begin
            if (exp_acc_vld) begin
                check("redir_target_addr", imem_addr, exp_acc_addr);
                exp_acc_vld = 0;
            end
            acc_addr_q.push_back(imem_addr);
            acc_edge_q.push_back(cur_edge);
            pend      = 1;
            pend_addr = imem_addr;
            pend_due  = cur_edge + int'($urandom_range(lat_max, lat_min));
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        pend = 0; stall_left = 0; stall_hook_en = 0; redir_hook_mode = 0;
        stall_hook_edge = -1; redir_hook_edge = -1;
        exp_acc_vld = 1; exp_acc_addr = 64'h0;
        sb_restart(64'h0);
        clear_logs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int stl, input int rdr);
        lat_min = lmin; lat_max = lmax; ready_pct = rdy; stall_pct = stl; redir_pct = rdr;
    endtask

    initial begin
        bit found;
        int idx;
        int d0;

        // Reset state
        apply_reset();
        check("rst_pc", IF_regs.pc, 64'h0);
        check("rst_inst", {32'h0, IF_regs.inst}, 64'h0);
        check("rst_pc4", IF_regs.pc4, 64'h0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_req", 64'(imem_req), 64'h1);
        check("rst_next_pc", next_pc, 64'h0);

        // 1-cycle memory, no stall: one instruction per cycle
        set_knobs(1, 1, 100, 0, 0);
        repeat (10) step();
        if (acc_addr_q.size() >= 3 && deliv_pc_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("b2b_acc_addr", acc_addr_q[i], 64'(i * 4));
                check("b2b_deliv_pc", deliv_pc_q[i], 64'(i * 4));
            end
            check("b2b_acc_gap", 64'(acc_edge_q[2] - acc_edge_q[0]), 64'd2);
            check("b2b_deliv_gap", 64'(deliv_edge_q[2] - deliv_edge_q[0]), 64'd2);
            check("b2b_first_lat", 64'(deliv_edge_q[0] - acc_edge_q[0]), 64'd1);
        end else begin
            check("b2b_count", 64'(deliv_pc_q.size()), 64'd3);
        end

        // Response three idle cycles after acceptance: one update every 4 cycles
        apply_reset();
        set_knobs(4, 4, 100, 0, 0);
        repeat (20) step();
        if (deliv_edge_q.size() >= 3) begin
            check("slow_gap0", 64'(deliv_edge_q[1] - deliv_edge_q[0]), 64'd4);
            check("slow_gap1", 64'(deliv_edge_q[2] - deliv_edge_q[1]), 64'd4);
        end else begin
            check("slow_count", 64'(deliv_edge_q.size()), 64'd3);
        end

        // Stall for 3 cycles as the 0x10 response arrives
        apply_reset();
        set_knobs(1, 1, 100, 0, 0);
        stall_hook_en = 1; stall_hook_addr = 64'h10;
        repeat (20) step();
        check("stall_hook_fired", 64'(stall_hook_edge >= 0), 64'h1);
        found = 0;
        foreach (deliv_pc_q[i]) begin
            if (deliv_pc_q[i] == 64'h10 && !found) begin
                found = 1;
                check("stall_release_edge", 64'(deliv_edge_q[i]), 64'(stall_hook_edge + 3));
            end
        end
        check("stall_0x10_delivered", 64'(found), 64'h1);
        found = 0;
        foreach (acc_addr_q[i]) begin
            if (acc_addr_q[i] == 64'h14 && !found) begin
                found = 1;
                check("stall_next_fetch_edge", 64'(acc_edge_q[i]), 64'(stall_hook_edge + 4));
            end
        end
        check("stall_0x14_fetched", 64'(found), 64'h1);

        // Redirect+flush while 0x20 is in flight, then redirect on the rvalid cycle of 0x108
        apply_reset();
        set_knobs(4, 4, 100, 0, 0);
        redir_hook_mode = 1; redir_hook_addr = 64'h20; redir_hook_tgt = 64'h100;
        repeat (40) step();
        check("inflight_redir_fired", 64'(redir_hook_edge >= 0), 64'h1);
        set_knobs(2, 2, 100, 0, 0);
        redir_hook_edge = -1;
        redir_hook_mode = 2; redir_hook_addr = 64'h108; redir_hook_tgt = 64'h200;
        repeat (30) step();
        check("rvalid_redir_fired", 64'(redir_hook_edge >= 0), 64'h1);

        // PC wrap at 2^64
        set_knobs(1, 1, 100, 0, 0);
        clear_logs();
        redir_hook_mode = 3; redir_hook_tgt = 64'hFFFF_FFFF_FFFF_FFF8;
        repeat (12) step();
        idx = -1;
        foreach (deliv_pc_q[i]) if (deliv_pc_q[i] == 64'hFFFF_FFFF_FFFF_FFFC && idx < 0) idx = i;
        if (idx >= 0 && idx + 1 < deliv_pc_q.size()) begin
            check("wrap_next_pc", deliv_pc_q[idx+1], 64'h0);
        end else begin
            check("wrap_seen", 64'(idx), 64'h1);
        end

        // Async reset in the middle of a wait
        apply_reset();
        set_knobs(4, 4, 100, 0, 0);
        repeat (10) step();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (pend && pend_due > cur_edge + 1) found = 1;
        end
        check("areset_wait_found", 64'(found), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_pc", IF_regs.pc, 64'h0);
        check("areset_inst", {32'h0, IF_regs.inst}, 64'h0);
        check("areset_addr", imem_addr, 64'h0);
        apply_reset();
        repeat (20) step();
        check("areset_restart", 64'(acc_addr_q.size() > 0 ? acc_addr_q[0] : 64'hDEAD), 64'h0);

        // Randomized traffic
        apply_reset();
        set_knobs(1, 5, 70, 25, 6);
        d0 = n_deliv;
        repeat (3000) step();
        check("random_liveness", 64'((n_deliv - d0) > 100), 64'h1);

        set_knobs(1, 1, 100, 0, 0);
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
